// File: rtl/accumulator_cpu_core.sv
// accumulator_cpu_core: multi-cycle accumulator CPU (fetch/decode/execute) driving a single-port synchronous RAM
module accumulator_cpu_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic                   mem_oe,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [DATA_WIDTH-1:0]  ac,
  output logic                   halted,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] retired
);
  typedef enum logic [2:0] {FETCH, FETCH_DATA, DECODE, MEM_RD, MEM_DATA, MEM_WR, HALTED} state_t;
  localparam logic [3:0] OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3, OP_SUBT = 4'h4;
  localparam logic [3:0] OP_HALT = 4'h7, OP_SKIP = 4'h8, OP_JUMP = 4'h9, OP_CLEAR = 4'hA;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] ir, mbr, operand;
  logic [ADDR_WIDTH-1:0] addr_q, addr_c, x;
  logic [3:0] opcode;
  logic [1:0] skip_sel;
  logic is_mem_rd, is_store, is_legal, is_stop, skip_take, retire, drive_rd, drive_wr;
  assign opcode = ir[DATA_WIDTH-1 -: 4];
  assign skip_sel = ir[DATA_WIDTH-5 -: 2];
  assign x = ir[ADDR_WIDTH-1:0];
  assign is_mem_rd = opcode inside {OP_LOAD, OP_ADD, OP_SUBT};
  assign is_store = opcode == OP_STORE;
  assign is_legal = is_mem_rd || is_store || (opcode inside {OP_HALT, OP_SKIP, OP_JUMP, OP_CLEAR});
  assign is_stop = !is_legal || opcode == OP_HALT;
  assign skip_take = skip_sel == 2'b00 ? ac[DATA_WIDTH-1] :
                     skip_sel == 2'b01 ? ac == '0 :
                     skip_sel == 2'b10 ? !ac[DATA_WIDTH-1] && ac != '0 : 1'b0;
  // MBR captures the read word; the ALU takes it straight from the bus in the capture cycle
  assign operand = state == MEM_DATA ? mem_rdata : mbr;
  always_comb begin
    state_n = state;
    drive_rd = 1'b0;
    drive_wr = 1'b0;
    addr_c = pc;
    retire = 1'b0;
    case (state)
      FETCH: begin
        drive_rd = run;
        state_n = run ? FETCH_DATA : FETCH;
      end
      FETCH_DATA: state_n = DECODE;
      DECODE: begin
        state_n = is_stop ? HALTED : is_mem_rd ? MEM_RD : is_store ? MEM_WR : FETCH;
        retire = is_legal && !is_mem_rd && !is_store;
      end
      MEM_RD: begin
        drive_rd = 1'b1;
        addr_c = x;
        state_n = MEM_DATA;
      end
      MEM_DATA: begin
        retire = 1'b1;
        state_n = FETCH;
      end
      MEM_WR: begin
        drive_wr = 1'b1;
        addr_c = x;
        retire = 1'b1;
        state_n = FETCH;
      end
      default: state_n = HALTED;
    endcase
  end
  assign mem_cs = !reset && (drive_rd || drive_wr);
  assign mem_oe = !reset && drive_rd;
  assign mem_we = !reset && drive_wr;
  assign mem_addr = mem_cs ? addr_c : addr_q;
  assign mem_wdata = ac;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      ac <= '0;
      ir <= '0;
      mbr <= '0;
      retired <= '0;
      halted <= 1'b0;
      illegal_op <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      if (mem_cs) addr_q <= addr_c;
      if (retire) retired <= retired + CNT_ONE;
      case (state)
        FETCH_DATA: begin
          ir <= mem_rdata;
          pc <= pc + PC_ONE;
        end
        DECODE: begin
          pc <= opcode == OP_JUMP ? x : opcode == OP_SKIP && skip_take ? pc + PC_ONE : pc;
          ac <= opcode == OP_CLEAR ? '0 : ac;
          halted <= is_stop;
          illegal_op <= !is_legal;
        end
        MEM_DATA: begin
          mbr <= mem_rdata;
          ac <= opcode == OP_LOAD ? operand : opcode == OP_ADD ? ac + operand : ac - operand;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_accumulator_cpu_core.sv
// tb_accumulator_cpu_core: directed and randomized programs checked against an ISA-level interpreter
module tb_accumulator_cpu_core;
  logic clock, reset, run, load;
  logic [27:0] mem_addr, pc, addr2, pc2;
  logic mem_cs, mem_we, mem_oe, halted, illegal_op, cs2, we2, oe2, halted2, ill2;
  logic [31:0] mem_wdata, mem_rdata, ac, wdata2, rdata2, ac2;
  logic [15:0] retired;
  logic [1:0] ret2;
  logic [31:0] mem [0:1023];
  logic [31:0] img [0:1023];
  logic [31:0] rm [0:1023];
  int passed = 0, total = 0, wr_count = 0, cs_count = 0, ctrl_bad = 0;

  accumulator_cpu_core dut (.clock(clock), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc(pc), .ac(ac),
    .halted(halted), .illegal_op(illegal_op), .retired(retired));
  accumulator_cpu_core #(.COUNT_WIDTH(2)) dut2 (.clock(clock), .reset(reset), .run(run), .mem_addr(addr2),
    .mem_cs(cs2), .mem_we(we2), .mem_oe(oe2), .mem_wdata(wdata2), .mem_rdata(rdata2), .pc(pc2), .ac(ac2),
    .halted(halted2), .illegal_op(ill2), .retired(ret2));

  initial begin clock = 0; forever #5 clock = ~clock; end

  always @(posedge clock) begin
    if (load) for (int i = 0; i < 1024; i++) mem[i] <= img[i];
    else if (mem_cs && mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    else if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr[9:0]];
    if (cs2 && oe2) rdata2 <= 32'h9000_0100;
  end

  always @(negedge clock) begin
    if (mem_cs && mem_we) wr_count++;
    if (mem_cs) cs_count++;
    if ((mem_we && mem_oe) || (reset && (mem_cs || mem_we || mem_oe)) || (we2 && oe2)) ctrl_bad++;
  end

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic do_reset();
    reset = 1; run = 0; load = 1; tick(); load = 0; tick(); reset = 0;
  endtask
  task automatic clear_img(); for (int i = 0; i < 1024; i++) img[i] = 32'h0; endtask
  task automatic exec(output int cyc, output bit to);
    do_reset(); run = 1; cyc = 0;
    while (!halted && cyc < 2000) begin tick(); cyc++; end
    to = !halted; run = 0;
  endtask

  // ISA-level interpreter: runs img from 0x100 until HALT or an illegal opcode
  task automatic model(output logic [27:0] mpc, output logic [31:0] mac, output int mret, output bit mill, output int mcyc);
    logic [31:0] ins; logic [27:0] x; bit done, take;
    for (int i = 0; i < 1024; i++) rm[i] = img[i];
    mpc = 28'h100; mac = 0; mret = 0; mill = 0; mcyc = 0; done = 0;
    while (!done) begin
      ins = rm[mpc[9:0]]; x = ins[27:0]; mpc = mpc + 1; mcyc += 3;
      case (ins[31:28])
        4'h1: begin mac = rm[x[9:0]]; mcyc += 2; mret++; end
        4'h3: begin mac = mac + rm[x[9:0]]; mcyc += 2; mret++; end
        4'h4: begin mac = mac - rm[x[9:0]]; mcyc += 2; mret++; end
        4'h2: begin rm[x[9:0]] = mac; mcyc += 1; mret++; end
        4'h7: begin mret++; done = 1; end
        4'h8: begin
          take = ins[27:26] == 0 ? $signed(mac) < 0 : ins[27:26] == 1 ? mac == 0 : ins[27:26] == 2 ? $signed(mac) > 0 : 0;
          if (take) mpc = mpc + 1;
          mret++;
        end
        4'h9: begin mpc = x; mret++; end
        4'hA: begin mac = 0; mret++; end
        default: begin mill = 1; done = 1; end
      endcase
      if (mcyc > 50000) done = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1; run = 1; load = 1; tick(); load = 0; tick();
    total++; if (pc !== 28'h100) $display("FAIL reset_pc: got %h want 100", pc); else passed++;
    total++; if (ac !== 0) $display("FAIL reset_ac: got %h want 0", ac); else passed++;
    total++; if (retired !== 0) $display("FAIL reset_retired: got %0d want 0", retired); else passed++;
    total++; if (halted !== 0 || illegal_op !== 0) $display("FAIL reset_flags: got %b%b want 00", halted, illegal_op); else passed++;
    total++; if (mem_cs !== 0 || mem_oe !== 0 || mem_we !== 0) $display("FAIL reset_ctrl: got cs=%b oe=%b we=%b want 000", mem_cs, mem_oe, mem_we); else passed++;
    reset = 0; run = 0;
  endtask

  task automatic test_program();
    int cyc; bit to;
    clear_img();
    img[256] = 32'h1000_0111; img[257] = 32'h3000_0112; img[258] = 32'h2000_0113; img[259] = 32'h7000_0000;
    img[273] = 32'h5; img[274] = 32'hFFFF_FFFE;
    exec(cyc, to);
    total++; if (to) $display("FAIL prog_timeout: halted never rose"); else passed++;
    total++; if (mem[275] !== 32'h3) $display("FAIL prog_mem113: got %h want 3", mem[275]); else passed++;
    total++; if (ac !== 32'h3) $display("FAIL prog_ac: got %h want 3", ac); else passed++;
    total++; if (retired !== 4) $display("FAIL prog_retired: got %0d want 4", retired); else passed++;
    total++; if (pc !== 28'h104) $display("FAIL prog_pc: got %h want 104", pc); else passed++;
    total++; if (illegal_op !== 0) $display("FAIL prog_illegal: got %b want 0", illegal_op); else passed++;
    total++; if (cyc !== 17) $display("FAIL prog_cycles: got %0d want 17", cyc); else passed++;
  endtask

  task automatic test_skipcond();
    logic [31:0] av [7]; logic [1:0] sv [7]; bit tk [7]; int cyc; bit to;
    av = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h5, 32'h8000_0000};
    sv = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00};
    tk = '{1, 0, 1, 0, 0, 1, 1};
    for (int k = 0; k < 7; k++) begin
      clear_img();
      img[256] = 32'h1000_0300; img[257] = {4'h8, sv[k], 26'd0}; img[258] = 32'h7000_0000; img[259] = 32'h7000_0000;
      img[768] = av[k];
      exec(cyc, to);
      total++; if (pc !== (tk[k] ? 28'h104 : 28'h103)) $display("FAIL skip_pc[%0d]: got %h want %h", k, pc, tk[k] ? 28'h104 : 28'h103); else passed++;
      total++; if (retired !== 3 || ac !== av[k]) $display("FAIL skip_state[%0d]: got ret=%0d ac=%h want 3 %h", k, retired, ac, av[k]); else passed++;
    end
  endtask

  task automatic test_jump();
    int n;
    clear_img(); img[256] = 32'h9000_0200; img[512] = 32'h7000_0000;
    do_reset(); run = 1; tick(); tick(); tick();
    total++; if (pc !== 28'h200 || retired !== 1) $display("FAIL jump_pc: got pc=%h ret=%0d want 200 1", pc, retired); else passed++;
    total++; if (mem_addr !== 28'h200 || mem_cs !== 1 || mem_oe !== 1) $display("FAIL jump_fetch: got addr=%h cs=%b oe=%b want 200 1 1", mem_addr, mem_cs, mem_oe); else passed++;
    n = 0; while (!halted && n < 100) begin tick(); n++; end
    total++; if (pc !== 28'h201 || n !== 3) $display("FAIL jump_halt: got pc=%h cyc=%0d want 201 3", pc, n); else passed++;
    run = 0;
  endtask

  task automatic test_illegal();
    logic [3:0] ops [8]; int cyc, w0, c0; bit to;
    ops = '{4'h0, 4'h5, 4'h6, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int k = 0; k < 8; k++) begin
      clear_img(); img[256] = {ops[k], 28'h300}; w0 = wr_count;
      exec(cyc, to);
      total++; if (halted !== 1 || illegal_op !== 1 || cyc !== 3) $display("FAIL illegal_trap[%h]: got h=%b i=%b cyc=%0d want 1 1 3", ops[k], halted, illegal_op, cyc); else passed++;
      total++; if (retired !== 0 || pc !== 28'h101 || wr_count !== w0) $display("FAIL illegal_state[%h]: got ret=%0d pc=%h wr=%0d want 0 101 0", ops[k], retired, pc, wr_count - w0); else passed++;
    end
    c0 = cs_count; run = 0; tick(); tick(); run = 1; repeat (5) tick(); run = 0;
    total++; if (cs_count !== c0 || pc !== 28'h101 || halted !== 1 || illegal_op !== 1) $display("FAIL illegal_frozen: got cs=%0d pc=%h h=%b want 0 101 1", cs_count - c0, pc, halted); else passed++;
  endtask

  task automatic test_stall();
    int c0, n;
    clear_img();
    img[256] = 32'h1000_0300; img[257] = 32'h3000_0301; img[258] = 32'h2000_0302; img[259] = 32'h7000_0000;
    img[768] = 32'h1234; img[769] = 32'h10;
    do_reset(); run = 1; tick(); run = 0; repeat (4) tick();
    total++; if (retired !== 1 || pc !== 28'h101 || ac !== 32'h1234) $display("FAIL stall_first: got ret=%0d pc=%h ac=%h want 1 101 1234", retired, pc, ac); else passed++;
    c0 = cs_count; repeat (10) tick();
    total++; if (cs_count !== c0) $display("FAIL stall_cs: got %0d accesses want 0", cs_count - c0); else passed++;
    total++; if (retired !== 1 || pc !== 28'h101 || ac !== 32'h1234) $display("FAIL stall_hold: got ret=%0d pc=%h ac=%h want 1 101 1234", retired, pc, ac); else passed++;
    run = 1; n = 0; while (!halted && n < 100) begin tick(); n++; end
    run = 0;
    total++; if (n !== 12) $display("FAIL stall_resume_cycles: got %0d want 12", n); else passed++;
    total++; if (ac !== 32'h1244 || mem[770] !== 32'h1244) $display("FAIL stall_result: got ac=%h m=%h want 1244", ac, mem[770]); else passed++;
    total++; if (retired !== 4 || pc !== 28'h104) $display("FAIL stall_end: got ret=%0d pc=%h want 4 104", retired, pc); else passed++;
  endtask

  task automatic test_reset_store();
    int w0;
    clear_img(); img[256] = 32'h1000_0300; img[257] = 32'h2000_0301; img[768] = 32'hABCD; img[769] = 32'h5555;
    do_reset(); w0 = wr_count; run = 1; repeat (7) tick();
    total++; if (retired !== 1 || ac !== 32'hABCD) $display("FAIL rst_store_pre: got ret=%0d ac=%h want 1 abcd", retired, ac); else passed++;
    reset = 1; tick();
    total++; if (pc !== 28'h100 || ac !== 0 || retired !== 0) $display("FAIL rst_store_regs: got pc=%h ac=%h ret=%0d want 100 0 0", pc, ac, retired); else passed++;
    reset = 0; run = 0; tick(); tick();
    total++; if (wr_count !== w0 || mem[769] !== 32'h5555) $display("FAIL rst_store_nowrite: got writes=%0d m=%h want 0 5555", wr_count - w0, mem[769]); else passed++;
  endtask

  task automatic test_random();
    logic [27:0] mpc, x; logic [31:0] mac, ins; int mret, mcyc, cyc, n, bad; bit mill, to;
    for (int it = 0; it < 24; it++) begin
      clear_img();
      for (int d = 0; d < 16; d++) img[768 + d] = d == 0 ? 32'h0 : d == 1 ? 32'h1 : d == 2 ? 32'hFFFF_FFFF : d == 3 ? 32'h8000_0000 : $urandom;
      n = $urandom_range(4, 12);
      for (int i = 0; i < n; i++) begin
        x = 28'h300 + 28'($urandom_range(0, 15));
        case ($urandom_range(0, 6))
          0: ins = {4'h1, x};
          1: ins = {4'h2, x};
          2: ins = {4'h3, x};
          3: ins = {4'h4, x};
          4: ins = {4'h8, 2'($urandom_range(0, 3)), 26'd0};
          5: ins = 32'hA000_0000;
          default: ins = {4'h9, 28'(256 + i + $urandom_range(1, 2))};
        endcase
        img[256 + i] = ins;
      end
      img[256 + n] = it % 4 == 3 ? {4'($urandom_range(11, 15)), 28'd0} : 32'h7000_0000;
      img[257 + n] = 32'h7000_0000;
      model(mpc, mac, mret, mill, mcyc);
      exec(cyc, to);
      total++; if (to || halted !== 1) $display("FAIL rnd_halt[%0d]: got halted=%b want 1", it, halted); else passed++;
      total++; if (pc !== mpc) $display("FAIL rnd_pc[%0d]: got %h want %h", it, pc, mpc); else passed++;
      total++; if (ac !== mac) $display("FAIL rnd_ac[%0d]: got %h want %h", it, ac, mac); else passed++;
      total++; if (retired !== 16'(mret)) $display("FAIL rnd_retired[%0d]: got %0d want %0d", it, retired, mret); else passed++;
      total++; if (illegal_op !== mill) $display("FAIL rnd_illegal[%0d]: got %b want %b", it, illegal_op, mill); else passed++;
      total++; if (cyc !== mcyc) $display("FAIL rnd_cycles[%0d]: got %0d want %0d", it, cyc, mcyc); else passed++;
      bad = 0; for (int d = 768; d < 784; d++) if (mem[d] !== rm[d]) bad++;
      total++; if (bad !== 0) $display("FAIL rnd_mem[%0d]: got %0d differing words want 0", it, bad); else passed++;
    end
  endtask

  task automatic test_wrap();
    do_reset(); run = 1; repeat (9) tick();
    total++; if (ret2 !== 2'd3 || pc2 !== 28'h100) $display("FAIL wrap_pre: got ret=%0d pc=%h want 3 100", ret2, pc2); else passed++;
    repeat (3) tick();
    total++; if (ret2 !== 2'd0) $display("FAIL wrap_zero: got %0d want 0", ret2); else passed++;
    repeat (3) tick(); run = 0;
    total++; if (ret2 !== 2'd1 || halted2 !== 0 || ill2 !== 0 || ac2 !== 0) $display("FAIL wrap_next: got ret=%0d h=%b want 1 0", ret2, halted2); else passed++;
  endtask

  task automatic test_mem_rules();
    total++; if (ctrl_bad !== 0) $display("FAIL mem_rules: got %0d bad control cycles want 0", ctrl_bad); else passed++;
  endtask

  initial begin
    reset = 1; run = 0; load = 0;
    clear_img();
    test_reset();
    test_program();
    test_skipcond();
    test_jump();
    test_illegal();
    test_stall();
    test_reset_store();
    test_random();
    test_wrap();
    test_mem_rules();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/accumulator_cpu_core.md
Name: accumulator_cpu_core

Overview:
Synthesisable, parametrised accumulator CPU core with a fetch/decode/execute state machine. It drives a single-port synchronous RAM (cs/we/oe interface, 1-cycle read latency) and replaces the procedural sequencing previously done in the CPU testbench. Additions over that sequencing:
- synchronous reset
- run/stall control
- halt state
- illegal-opcode trap
- retired-instruction counter

Parameters:
DATA_WIDTH, 32, word width of AC, IR, MBR and memory data; must be >= ADDR_WIDTH+4
ADDR_WIDTH, 28, memory address width; PC width
RESET_PC, 'h100, PC value loaded on reset
COUNT_WIDTH, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  1 = start new instructions; 0 = stall at instruction boundary
mem_addr  out  ADDR_WIDTH  RAM address
mem_cs  out  1  RAM chip select
mem_we  out  1  RAM write enable
mem_oe  out  1  RAM output enable
mem_wdata  out  DATA_WIDTH  RAM write data (= AC)
mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after address issued with cs=1, oe=1
pc  out  ADDR_WIDTH  current PC
ac  out  DATA_WIDTH  accumulator
halted  out  1  core stopped (HALT or illegal opcode)
illegal_op  out  1  stopped because of illegal opcode
retired  out  COUNT_WIDTH  instructions completed, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset (sampled high at a posedge):
  - PC=RESET_PC; AC, IR, MBR=0; retired=0; halted=0; illegal_op=0; state=FETCH.
  - Asserting reset mid-instruction aborts it; no memory write occurs in any cycle where reset is high.
  - Memory controls are forced to cs=we=oe=0 while reset is high.
- Instruction format:
  - opcode = IR[DATA_WIDTH-1:DATA_WIDTH-4]
  - operand address X = IR[ADDR_WIDTH-1:0]
  - skip field S = IR[DATA_WIDTH-5:DATA_WIDTH-6]
- Opcodes:
  - 1 LOAD: AC<=M[X]
  - 2 STORE: M[X]<=AC
  - 3 ADD: AC<=AC+M[X]
  - 4 SUBT: AC<=AC-M[X]
  - 7 HALT
  - 8 SKIPCOND: S=00 skip if AC<0 (signed); 01 skip if AC==0; 10 skip if AC>0 (signed); 11 never skip
  - 9 JUMP: PC<=X
  - A CLEAR: AC<=0
  - All other opcodes (0,5,6,B-F) are illegal.
- Arithmetic: two's complement, modulo 2^DATA_WIDTH, no flags. PC increments modulo 2^ADDR_WIDTH (wrap-around).
- States:
  - FETCH:
    - run=1: mem_addr=PC, cs=1, oe=1, we=0; next FETCH_DATA.
    - run=0: cs=0; stay in FETCH.
  - FETCH_DATA: IR<=mem_rdata; PC<=PC+1; next DECODE.
  - DECODE:
    - LOAD/ADD/SUBT -> MEM_RD
    - STORE -> MEM_WR
    - JUMP: PC<=X, retire, -> FETCH
    - SKIPCOND: if condition true PC<=PC+1; retire; -> FETCH
    - CLEAR: AC<=0, retire, -> FETCH
    - HALT: retire, halted<=1, -> HALTED
    - illegal: halted<=1, illegal_op<=1, no retire, -> HALTED
  - MEM_RD: mem_addr=X, cs=1, oe=1; next MEM_DATA.
  - MEM_DATA: MBR<=mem_rdata; AC updated from mem_rdata per opcode; retire; -> FETCH.
  - MEM_WR: mem_addr=X, cs=1, we=1, oe=0, mem_wdata=AC; retire; -> FETCH.
  - HALTED: cs=we=oe=0; all registers frozen. Left only by reset; run is ignored.
- Memory signal rules:
  - Memory outputs are a combinational decode of state, PC and IR.
  - Outside MEM_RD, MEM_WR and active FETCH: cs=we=oe=0.
  - mem_addr holds its last driven value when idle.
  - we and oe are never both 1.
- Latency (clocks from FETCH entry with run=1): LOAD/ADD/SUBT 5; STORE 4; JUMP/SKIPCOND/CLEAR/HALT 3.
- Retire rules: retired increments by exactly 1 on the final cycle of each legal instruction, including HALT.
- run is sampled only in FETCH. Deasserting run mid-instruction completes that instruction, then stalls.
- SKIPCOND with PC at the top of the address space wraps to 0.

Test Plan:
- Reset then run=1 with M[100]=1000_0111, M[101]=3000_0112, M[102]=2000_0113, M[103]=7000_0000, M[111]=5, M[112]=FFFF_FFFE -> M[113]=3, ac=3, halted=1, retired=4, pc=104, illegal_op=0.
- SKIPCOND coverage: AC=0 with 8400_0000 (S=01) -> PC advances by 2. Same instruction with AC=1 -> PC advances by 1. AC=FFFF_FFFF with S=00 -> skip. AC=FFFF_FFFF with S=10 -> no skip. S=11 -> never skips.
- Program 9000_0200 at 100 -> pc=200 after 3 cycles; next fetch address 200.
- Opcode F at 100 -> halted=1, illegal_op=1, retired=0, no memory write ever asserted; raising run again changes nothing.
- run=0 for 10 cycles between instructions -> cs stays 0, pc/ac/retired unchanged; resumes exactly where stalled.
- reset asserted during MEM_WR-bound STORE (DECODE cycle) -> no write, pc=100, ac=0, retired=0 next cycle; counter wrap with COUNT_WIDTH=2 after 4 retires -> retired=0.
